vmu_mem_arbiter: RTL and testbench
==================================

Name: vmu_mem_arbiter

Overview:
- Shares the single cache/memory request port between the vector memory unit (load and store engines) and the scalar CPU data port.
- Registered request stage, round-robin arbitration with burst limit, read-outstanding credit counter and tag-based response routing.
- Fence/drain state machine so the core can order scalar accesses after in-flight vector traffic.
- Sits between the vector unit's memory interface and the L1/bus adapter.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, request/response data width.
- TICKET_WIDTH, 4, vector ticket width ($clog2(8)+1).
- MAX_OUTSTANDING, 8, max in-flight reads (both sources combined).
- BURST_LIMIT, 4, max consecutive grants to one source while the other is waiting.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- vec_req_valid_i  in  1  vector request valid
- vec_req_store_i  in  1  1=store, 0=load
- vec_req_addr_i  in  ADDR_WIDTH  vector address
- vec_req_data_i  in  DATA_WIDTH  vector store data
- vec_req_ticket_i  in  TICKET_WIDTH  vector load ticket
- vec_req_ready_o  out  1  vector request accepted this cycle
- vec_resp_valid_o  out  1  vector load response
- vec_resp_ticket_o  out  TICKET_WIDTH  returned ticket
- vec_resp_data_o  out  DATA_WIDTH  returned data
- sca_req_valid_i  in  1  scalar request valid
- sca_req_we_i  in  1  scalar write enable
- sca_req_addr_i  in  ADDR_WIDTH  scalar address
- sca_req_data_i  in  DATA_WIDTH  scalar write data
- sca_req_ready_o  out  1  scalar request accepted
- sca_resp_valid_o  out  1  scalar read response
- sca_resp_data_o  out  DATA_WIDTH  scalar read data
- mem_req_valid_o  out  1  memory request valid (registered)
- mem_req_we_o  out  1  memory write
- mem_req_addr_o  out  ADDR_WIDTH  memory address
- mem_req_data_o  out  DATA_WIDTH  memory write data
- mem_req_tag_o  out  TICKET_WIDTH+1  {source, ticket}; source 1=vector, 0=scalar (scalar ticket=0)
- mem_req_ready_i  in  1  memory accepts request
- mem_resp_valid_i  in  1  memory read response
- mem_resp_tag_i  in  TICKET_WIDTH+1  echoed tag
- mem_resp_data_i  in  DATA_WIDTH  read data
- fence_i  in  1  request drain (level, held until fence_ack_o)
- fence_ack_o  out  1  one-cycle pulse: drain complete
- arb_idle_o  out  1  output stage empty, outstanding=0, no valid input

Behaviour:
- Reset (rst_n=0 at posedge): mem_req_valid_o=0, all mem_req_* payload=0, outstanding=0, burst_cnt=0, last_grant=vector (scalar wins first tie), state=ARB_RUN, fence_ack_o=0. Response outputs are combinational and 0 while mem_resp_valid_i=0. Reset mid-transaction discards the output stage; responses arriving afterwards are routed but do not decrement below 0.
- Output stage: one register. slot_free = ~mem_req_valid_o | mem_req_ready_i. Grant only when slot_free, state=ARB_RUN, and credit OK. Grant loads the stage next cycle: request-to-mem latency 1.
- Credit: a read grant requires outstanding < MAX_OUTSTANDING; writes need no credit.
  - outstanding increments when a read is loaded into the stage; decrements on mem_resp_valid_i.
  - Both in the same cycle: unchanged.
  - Saturates at 0; never exceeds MAX_OUTSTANDING.
  - A source blocked by credit is treated as not valid for arbitration.
- Arbitration, only one eligible: grant it.
- Arbitration, both eligible: grant last_grant's source if burst_cnt < BURST_LIMIT, else the other.
  - burst_cnt resets to 1 on a switch and increments on a repeat grant.
  - With no contention, burst_cnt holds at BURST_LIMIT (no wrap).
- ready_o: vec_req_ready_o / sca_req_ready_o are combinational, high only in the grant cycle. The source holds valid/payload until ready.
- Response routing: mem_resp_tag_i MSB=1 → vec_resp_valid_o, ticket=tag[TICKET_WIDTH-1:0]. MSB=0 → sca_resp_valid_o. Zero latency, no buffering.
- FSM:
  - ARB_RUN: fence_i=1 → ARB_DRAIN; no grant that cycle.
  - ARB_DRAIN: no grants. When mem_req_valid_o=0 and outstanding=0 → ARB_ACK.
  - ARB_ACK: fence_ack_o=1 for one cycle → ARB_RUN.
  - fence_i deasserting early in DRAIN does not abort the drain.
- Simultaneous fence_i and valid requests: the fence wins, and requests wait.

Decomposition:
- Shared package holds:
  - arb_state_e (ARB_RUN, ARB_DRAIN, ARB_ACK).
  - mem_src_e (SRC_SCALAR=0, SRC_VECTOR=1).
  - The arb_mem_req struct {we, addr, data, tag}.
- One natural sub-module: vmu_arb_rr2, the 2-way round-robin picker with burst counter, inputs eligible[1:0], output grant one-hot.

Test Plan:
- Contention: both sources valid continuously with writes, mem_req_ready_i=1 → grants S,S,S,S,V,V,V,V,S… (BURST_LIMIT=4); first mem_req_valid_o one cycle after the first grant.
- Credit: 8 vector loads, no responses → 9th load stalls with vec_req_ready_o=0 while a scalar write is still granted. One response → the 9th load is granted next cycle.
- Backpressure: mem_req_ready_i=0 for 5 cycles → stage payload stable, no ready_o to either source. Release → the next grant occurs in the same cycle.
- Routing: responses with tag 5'b1_0011 data 0xDEADBEEF → vec_resp_valid_o=1, ticket 3. Tag 5'b0_0000 → sca_resp_valid_o=1. Response plus new read in the same cycle → outstanding unchanged.
- Fence: 3 loads outstanding, fence_i=1 → no grants. fence_ack_o pulses exactly 1 cycle after the 3rd response with the stage empty, then grants resume.
- Reset: rst_n=0 mid-burst with the stage full → next cycle mem_req_valid_o=0, outstanding=0. A stray response after reset routes without underflow, and arb_idle_o=1.

Source files
------------

// File: rtl/vmu_mem_arbiter_pkg.sv
// rtl/vmu_mem_arbiter_pkg.sv - shared types for the vector/scalar memory port arbiter
package vmu_mem_arbiter_pkg;

  localparam int ARB_ADDR_W   = 32;
  localparam int ARB_DATA_W   = 32;
  localparam int ARB_TICKET_W = 4;
  localparam int ARB_TAG_W    = ARB_TICKET_W + 1;

  typedef enum logic [1:0] {
    ARB_RUN   = 2'd0,
    ARB_DRAIN = 2'd1,
    ARB_ACK   = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_SCALAR = 1'b0,
    SRC_VECTOR = 1'b1
  } mem_src_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
    logic [ARB_TAG_W-1:0]  tag;
  } arb_mem_req_t;

  // Tag MSB carries the source; scalar requests always carry ticket 0.
  function automatic logic [ARB_TAG_W-1:0] make_tag(input mem_src_e src,
                                                    input logic [ARB_TICKET_W-1:0] ticket);
    logic [ARB_TICKET_W-1:0] t;
    t = (src == SRC_VECTOR) ? ticket : '0;
    return {src == SRC_VECTOR, t};
  endfunction

endpackage

// File: rtl/vmu_arb_rr2.sv
// rtl/vmu_arb_rr2.sv - two-way round-robin picker with per-source burst limit
module vmu_arb_rr2
  import vmu_mem_arbiter_pkg::*;
#(
  parameter int BURST_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance_i,
  input  logic [1:0] eligible_i,
  output logic [1:0] grant_o
);

  localparam int CNT_W = $clog2(BURST_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BURST_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mem_src_e         last_q, last_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  mem_src_e         pick;
  logic             keep_last;

  // Choose a source; burst count 0 means no history, so the tie goes away from last_q.
  always_comb begin
    grant_o   = 2'b00;
    last_d    = last_q;
    burst_d   = burst_q;
    keep_last = (burst_q != '0) && (burst_q < CNT_LIMIT);
    pick      = last_q;
    case (eligible_i)
      2'b01:   pick = SRC_SCALAR;
      2'b10:   pick = SRC_VECTOR;
      2'b11:   pick = keep_last ? last_q : mem_src_e'(~last_q);
      default: pick = last_q;
    endcase
    if (advance_i && (eligible_i != 2'b00)) begin
      grant_o = (pick == SRC_VECTOR) ? 2'b10 : 2'b01;
      last_d  = pick;
      if ((pick == last_q) && (burst_q != '0)) begin
        burst_d = (burst_q < CNT_LIMIT) ? burst_q + CNT_ONE : burst_q;
      end else begin
        burst_d = CNT_ONE;
      end
    end
  end

  // Remember the last winner and how many times in a row it has won.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= SRC_VECTOR;
      burst_q <= '0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/vmu_mem_arbiter.sv
// rtl/vmu_mem_arbiter.sv - shares one memory request port between vector unit and scalar core
module vmu_mem_arbiter
  import vmu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = ARB_ADDR_W,
  parameter int DATA_WIDTH      = ARB_DATA_W,
  parameter int TICKET_WIDTH    = ARB_TICKET_W,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BURST_LIMIT     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vec_req_valid_i,
  input  logic                    vec_req_store_i,
  input  logic [ADDR_WIDTH-1:0]   vec_req_addr_i,
  input  logic [DATA_WIDTH-1:0]   vec_req_data_i,
  input  logic [TICKET_WIDTH-1:0] vec_req_ticket_i,
  output logic                    vec_req_ready_o,
  output logic                    vec_resp_valid_o,
  output logic [TICKET_WIDTH-1:0] vec_resp_ticket_o,
  output logic [DATA_WIDTH-1:0]   vec_resp_data_o,
  input  logic                    sca_req_valid_i,
  input  logic                    sca_req_we_i,
  input  logic [ADDR_WIDTH-1:0]   sca_req_addr_i,
  input  logic [DATA_WIDTH-1:0]   sca_req_data_i,
  output logic                    sca_req_ready_o,
  output logic                    sca_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   sca_resp_data_o,
  output logic                    mem_req_valid_o,
  output logic                    mem_req_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_req_data_o,
  output logic [TICKET_WIDTH:0]   mem_req_tag_o,
  input  logic                    mem_req_ready_i,
  input  logic                    mem_resp_valid_i,
  input  logic [TICKET_WIDTH:0]   mem_resp_tag_i,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data_i,
  input  logic                    fence_i,
  output logic                    fence_ack_o,
  output logic                    arb_idle_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  arb_mem_req_t     stage_q, stage_d;
  logic             stage_valid_q, stage_valid_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  arb_state_e       state_q, state_d;

  logic       slot_free;
  logic       credit_ok;
  logic       grant_en;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       grant_read;

  assign slot_free = ~stage_valid_q | mem_req_ready_i;
  assign credit_ok = outst_q < OUT_MAX;
  assign grant_en  = slot_free & (state_q == ARB_RUN) & ~fence_i;

  // A read blocked by credit looks idle to the picker so a pending write can go ahead.
  assign eligible[1] = vec_req_valid_i & (vec_req_store_i | credit_ok);
  assign eligible[0] = sca_req_valid_i & (sca_req_we_i | credit_ok);

  vmu_arb_rr2 #(
    .BURST_LIMIT(BURST_LIMIT)
  ) u_rr2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (grant_en),
    .eligible_i(eligible),
    .grant_o   (grant)
  );

  assign vec_req_ready_o = grant[1];
  assign sca_req_ready_o = grant[0];
  assign grant_read      = (grant[1] & ~vec_req_store_i) | (grant[0] & ~sca_req_we_i);

  // Output stage: a grant reloads it, an accepted request empties it, otherwise it holds.
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_d       = stage_q;
    if (mem_req_ready_i) begin
      stage_valid_d = 1'b0;
    end
    if (grant[1]) begin
      stage_valid_d = 1'b1;
      stage_d.we    = vec_req_store_i;
      stage_d.addr  = vec_req_addr_i;
      stage_d.data  = vec_req_data_i;
      stage_d.tag   = make_tag(SRC_VECTOR, vec_req_ticket_i);
    end else if (grant[0]) begin
      stage_valid_d = 1'b1;
      stage_d.we    = sca_req_we_i;
      stage_d.addr  = sca_req_addr_i;
      stage_d.data  = sca_req_data_i;
      stage_d.tag   = make_tag(SRC_SCALAR, '0);
    end
  end

  // Read credit: count loads into the stage, retire on responses, floor at zero.
  always_comb begin
    outst_d = outst_q;
    case ({grant_read, mem_resp_valid_i})
      2'b10:   outst_d = (outst_q < OUT_MAX) ? outst_q + OUT_ONE : outst_q;
      2'b01:   outst_d = (outst_q != '0) ? outst_q - OUT_ONE : outst_q;
      default: outst_d = outst_q;
    endcase
  end

  // Fence sequencing: stop granting, wait for the port to go quiet, then acknowledge once.
  always_comb begin
    state_d     = state_q;
    fence_ack_o = 1'b0;
    case (state_q)
      ARB_RUN: begin
        if (fence_i) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!stage_valid_q && (outst_d == '0)) state_d = ARB_ACK;
      end
      ARB_ACK: begin
        fence_ack_o = 1'b1;
        state_d     = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  // State, credit and output stage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_RUN;
      outst_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
    end else begin
      state_q       <= state_d;
      outst_q       <= outst_d;
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
    end
  end

  assign mem_req_valid_o = stage_valid_q;
  assign mem_req_we_o    = stage_q.we;
  assign mem_req_addr_o  = stage_q.addr;
  assign mem_req_data_o  = stage_q.data;
  assign mem_req_tag_o   = stage_q.tag;

  // Responses are steered by the tag source bit with no storage in between.
  assign vec_resp_valid_o  = mem_resp_valid_i & mem_resp_tag_i[TICKET_WIDTH];
  assign sca_resp_valid_o  = mem_resp_valid_i & ~mem_resp_tag_i[TICKET_WIDTH];
  assign vec_resp_ticket_o = vec_resp_valid_o ? mem_resp_tag_i[TICKET_WIDTH-1:0] : '0;
  assign vec_resp_data_o   = vec_resp_valid_o ? mem_resp_data_i : '0;
  assign sca_resp_data_o   = sca_resp_valid_o ? mem_resp_data_i : '0;

  assign arb_idle_o = ~stage_valid_q & (outst_q == '0) & ~vec_req_valid_i & ~sca_req_valid_i;

endmodule

// File: tb/tb_vmu_mem_arbiter.sv
// tb/tb_vmu_mem_arbiter.sv - scoreboard bench for vmu_mem_arbiter
module tb_vmu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_req_valid_i, vec_req_store_i;
  logic [31:0] vec_req_addr_i, vec_req_data_i;
  logic [3:0]  vec_req_ticket_i;
  logic        vec_req_ready_o, vec_resp_valid_o;
  logic [3:0]  vec_resp_ticket_o;
  logic [31:0] vec_resp_data_o;
  logic        sca_req_valid_i, sca_req_we_i;
  logic [31:0] sca_req_addr_i, sca_req_data_i;
  logic        sca_req_ready_o, sca_resp_valid_o;
  logic [31:0] sca_resp_data_o;
  logic        mem_req_valid_o, mem_req_we_o;
  logic [31:0] mem_req_addr_o, mem_req_data_o;
  logic [4:0]  mem_req_tag_o;
  logic        mem_req_ready_i, mem_resp_valid_i;
  logic [4:0]  mem_resp_tag_i;
  logic [31:0] mem_resp_data_i;
  logic        fence_i, fence_ack_o, arb_idle_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [4:0] tag; } req_t;
  typedef struct { logic vec; logic [3:0] ticket; logic [31:0] data; } resp_t;
  req_t  exp_req[$];
  resp_t exp_resp[$];

  always #5 clk = ~clk;

  vmu_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .vec_req_valid_i(vec_req_valid_i), .vec_req_store_i(vec_req_store_i),
    .vec_req_addr_i(vec_req_addr_i), .vec_req_data_i(vec_req_data_i),
    .vec_req_ticket_i(vec_req_ticket_i), .vec_req_ready_o(vec_req_ready_o),
    .vec_resp_valid_o(vec_resp_valid_o), .vec_resp_ticket_o(vec_resp_ticket_o),
    .vec_resp_data_o(vec_resp_data_o),
    .sca_req_valid_i(sca_req_valid_i), .sca_req_we_i(sca_req_we_i),
    .sca_req_addr_i(sca_req_addr_i), .sca_req_data_i(sca_req_data_i),
    .sca_req_ready_o(sca_req_ready_o), .sca_resp_valid_o(sca_resp_valid_o),
    .sca_resp_data_o(sca_resp_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_tag_o(mem_req_tag_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_tag_i(mem_resp_tag_i),
    .mem_resp_data_i(mem_resp_data_i),
    .fence_i(fence_i), .fence_ack_o(fence_ack_o), .arb_idle_o(arb_idle_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] t);
    req_t r;
    r.we = we; r.addr = a; r.data = d; r.tag = t;
    exp_req.push_back(r);
  endtask

  task automatic push_resp(input logic v, input logic [3:0] t, input logic [31:0] d);
    resp_t r;
    r.vec = v; r.ticket = t; r.data = d;
    exp_resp.push_back(r);
  endtask

  task automatic set_vec(input logic v, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] t);
    vec_req_valid_i = v; vec_req_store_i = st; vec_req_addr_i = a;
    vec_req_data_i = d; vec_req_ticket_i = t;
  endtask

  task automatic set_sca(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    sca_req_valid_i = v; sca_req_we_i = we; sca_req_addr_i = a; sca_req_data_i = d;
  endtask

  task automatic set_resp(input logic v, input logic [4:0] tag, input logic [31:0] d);
    mem_resp_valid_i = v; mem_resp_tag_i = tag; mem_resp_data_i = d;
  endtask

  // Memory-side monitor: every accepted request must match the next expected one.
  always @(negedge clk) begin : mon_req
    req_t e;
    if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
      if (exp_req.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mem_req_unexpected: got addr 0x%0h, expected no request", mem_req_addr_o);
      end else begin
        e = exp_req.pop_front();
        chk("mem_req_we", 32'(mem_req_we_o), 32'(e.we));
        chk("mem_req_addr", mem_req_addr_o, e.addr);
        chk("mem_req_data", mem_req_data_o, e.data);
        chk("mem_req_tag", 32'(mem_req_tag_o), 32'(e.tag));
      end
    end
  end

  // Response monitor: each routed response must match the next expected one.
  always @(negedge clk) begin : mon_resp
    resp_t e;
    if (vec_resp_valid_o || sca_resp_valid_o) begin
      if (exp_resp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL resp_unexpected: got vec=%0b sca=%0b, expected none",
                 vec_resp_valid_o, sca_resp_valid_o);
      end else begin
        e = exp_resp.pop_front();
        chk("resp_vec_valid", 32'(vec_resp_valid_o), 32'(e.vec));
        chk("resp_sca_valid", 32'(sca_resp_valid_o), 32'(!e.vec));
        if (e.vec) begin
          chk("resp_vec_ticket", 32'(vec_resp_ticket_o), 32'(e.ticket));
          chk("resp_vec_data", vec_resp_data_o, e.data);
        end else begin
          chk("resp_sca_data", sca_resp_data_o, e.data);
        end
      end
    end
  end

  bit exp_vec_grant [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin : stim
    int vi;
    int si;
    vi = 0;
    si = 0;
    rst_n = 1'b0;
    mem_req_ready_i = 1'b1;
    fence_i = 1'b0;
    set_vec(0, 0, 0, 0, 0);
    set_sca(0, 0, 0, 0);
    set_resp(0, 0, 0);
    repeat (2) tick();

    @(negedge clk);
    chk("rst_mem_valid", 32'(mem_req_valid_o), 0);
    chk("rst_mem_addr", mem_req_addr_o, 0);
    chk("rst_mem_tag", 32'(mem_req_tag_o), 0);
    chk("rst_fence_ack", 32'(fence_ack_o), 0);
    chk("rst_idle", 32'(arb_idle_o), 1);
    chk("rst_resp_quiet", 32'(vec_resp_valid_o | sca_resp_valid_o), 0);
    tick();
    rst_n = 1'b1;

    // Contention with writes: S,S,S,S,V,V,V,V,S,S
    for (int c = 0; c < 10; c++) begin
      set_vec(1, 1, 32'h1000 + vi, 32'hA000_0000 + vi, 4'h0);
      set_sca(1, 1, 32'h2000 + si, 32'hB000_0000 + si);
      @(negedge clk);
      chk($sformatf("cont_vec_ready_%0d", c), 32'(vec_req_ready_o), 32'(exp_vec_grant[c]));
      chk($sformatf("cont_sca_ready_%0d", c), 32'(sca_req_ready_o), 32'(!exp_vec_grant[c]));
      if (c == 0) chk("cont_first_mem_valid", 32'(mem_req_valid_o), 0);
      if (c == 1) chk("cont_second_mem_valid", 32'(mem_req_valid_o), 1);
      if (exp_vec_grant[c]) begin
        push_req(1, 32'h1000 + vi, 32'hA000_0000 + vi, 5'h10);
        vi++;
      end else begin
        push_req(1, 32'h2000 + si, 32'hB000_0000 + si, 5'h00);
        si++;
      end
      tick();
    end
    set_vec(0, 0, 0, 0, 0);
    set_sca(0, 0, 0, 0);
    @(negedge clk);
    tick();

    // Credit: eight loads fill the budget
    for (int i = 0; i < 8; i++) begin
      set_vec(1, 0, 32'h3000 + i, 0, i[3:0]);
      @(negedge clk);
      chk($sformatf("credit_load_%0d", i), 32'(vec_req_ready_o), 1);
      push_req(0, 32'h3000 + i, 0, {1'b1, i[3:0]});
      tick();
    end
    set_vec(1, 0, 32'h3008, 0, 4'h8);
    set_sca(1, 1, 32'h4000, 32'h4444_0000);
    @(negedge clk);
    chk("credit_vec_stall", 32'(vec_req_ready_o), 0);
    chk("credit_sca_write", 32'(sca_req_ready_o), 1);
    push_req(1, 32'h4000, 32'h4444_0000, 5'h00);
    tick();
    set_sca(0, 0, 0, 0);
    @(negedge clk);
    chk("credit_vec_stall2", 32'(vec_req_ready_o), 0);
    tick();
    set_resp(1, 5'h10, 32'h1111_0000);
    push_resp(1, 4'h0, 32'h1111_0000);
    @(negedge clk);
    chk("credit_vec_stall_resp", 32'(vec_req_ready_o), 0);
    tick();
    set_resp(0, 0, 0);
    @(negedge clk);
    chk("credit_release", 32'(vec_req_ready_o), 1);
    push_req(0, 32'h3008, 0, 5'h18);
    tick();
    set_vec(0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      set_resp(1, {1'b1, i[3:0]}, 32'h1111_0000 + i);
      push_resp(1, i[3:0], 32'h1111_0000 + i);
      tick();
    end
    set_resp(0, 0, 0);
    @(negedge clk);
    chk("credit_idle", 32'(arb_idle_o), 1);
    tick();

    // Backpressure
    mem_req_ready_i = 1'b0;
    set_sca(1, 1, 32'h5000, 32'h5555_0000);
    @(negedge clk);
    chk("bp_first_grant", 32'(sca_req_ready_o), 1);
    push_req(1, 32'h5000, 32'h5555_0000, 5'h00);
    tick();
    set_sca(1, 1, 32'h5004, 32'h5555_0004);
    set_vec(1, 1, 32'h6000, 32'h6666_0000, 4'h2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_no_vec_%0d", k), 32'(vec_req_ready_o), 0);
      chk($sformatf("bp_no_sca_%0d", k), 32'(sca_req_ready_o), 0);
      chk($sformatf("bp_addr_%0d", k), mem_req_addr_o, 32'h5000);
      chk($sformatf("bp_data_%0d", k), mem_req_data_o, 32'h5555_0000);
      tick();
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_sca", 32'(sca_req_ready_o), 1);
    chk("bp_release_vec", 32'(vec_req_ready_o), 0);
    push_req(1, 32'h5004, 32'h5555_0004, 5'h00);
    tick();
    set_sca(0, 0, 0, 0);
    @(negedge clk);
    chk("bp_vec_after", 32'(vec_req_ready_o), 1);
    push_req(1, 32'h6000, 32'h6666_0000, 5'h12);
    tick();
    set_vec(0, 0, 0, 0, 0);
    @(negedge clk);
    tick();

    // Response routing
    set_resp(1, 5'b1_0011, 32'hDEAD_BEEF);
    push_resp(1, 4'h3, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("route_vec_valid", 32'(vec_resp_valid_o), 1);
    chk("route_vec_ticket", 32'(vec_resp_ticket_o), 3);
    chk("route_sca_quiet", 32'(sca_resp_valid_o), 0);
    tick();
    set_resp(1, 5'b0_0000, 32'hCAFE_F00D);
    push_resp(0, 4'h0, 32'hCAFE_F00D);
    @(negedge clk);
    chk("route_sca_valid", 32'(sca_resp_valid_o), 1);
    chk("route_vec_quiet", 32'(vec_resp_valid_o), 0);
    tick();
    set_resp(0, 0, 0);
    set_sca(1, 0, 32'h7000, 0);
    @(negedge clk);
    chk("route_read1", 32'(sca_req_ready_o), 1);
    push_req(0, 32'h7000, 0, 5'h00);
    tick();
    set_sca(1, 0, 32'h7004, 0);
    set_resp(1, 5'h00, 32'h7777_0000);
    push_resp(0, 4'h0, 32'h7777_0000);
    @(negedge clk);
    chk("route_read2", 32'(sca_req_ready_o), 1);
    push_req(0, 32'h7004, 0, 5'h00);
    tick();
    set_sca(0, 0, 0, 0);
    set_resp(0, 0, 0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("route_outst_held", 32'(arb_idle_o), 0);
    tick();
    set_resp(1, 5'h00, 32'h7777_0004);
    push_resp(0, 4'h0, 32'h7777_0004);
    @(negedge clk);
    tick();
    set_resp(0, 0, 0);
    @(negedge clk);
    chk("route_outst_zero", 32'(arb_idle_o), 1);
    tick();

    // Fence with three loads in flight; fence drops early mid-drain
    for (int i = 0; i < 3; i++) begin
      set_vec(1, 0, 32'h8000 + 4 * i, 0, i[3:0]);
      @(negedge clk);
      chk($sformatf("fence_load_%0d", i), 32'(vec_req_ready_o), 1);
      push_req(0, 32'h8000 + 4 * i, 0, {1'b1, i[3:0]});
      tick();
    end
    set_vec(0, 0, 0, 0, 0);
    set_sca(1, 1, 32'h9000, 32'h9999_0000);
    fence_i = 1'b1;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      chk($sformatf("fence_block_%0d", f), 32'(sca_req_ready_o), 0);
      chk($sformatf("fence_no_ack_%0d", f), 32'(fence_ack_o), 0);
      tick();
    end
    fence_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      set_resp(1, {1'b1, r[3:0]}, 32'h8888_0000 + r);
      push_resp(1, r[3:0], 32'h8888_0000 + r);
      @(negedge clk);
      chk($sformatf("fence_drain_block_%0d", r), 32'(sca_req_ready_o), 0);
      chk($sformatf("fence_drain_no_ack_%0d", r), 32'(fence_ack_o), 0);
      tick();
    end
    set_resp(0, 0, 0);
    @(negedge clk);
    chk("fence_ack_pulse", 32'(fence_ack_o), 1);
    chk("fence_ack_no_grant", 32'(sca_req_ready_o), 0);
    tick();
    @(negedge clk);
    chk("fence_ack_single", 32'(fence_ack_o), 0);
    chk("fence_resume", 32'(sca_req_ready_o), 1);
    push_req(1, 32'h9000, 32'h9999_0000, 5'h00);
    tick();
    set_sca(0, 0, 0, 0);
    @(negedge clk);
    tick();

    // Reset with the stage full and a read counted
    mem_req_ready_i = 1'b0;
    set_vec(1, 0, 32'hA000, 0, 4'h5);
    @(negedge clk);
    chk("rst_mid_grant", 32'(vec_req_ready_o), 1);
    tick();
    set_vec(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_stage_full", 32'(mem_req_valid_o), 1);
    tick();
    @(negedge clk);
    chk("rst_mid_stage_empty", 32'(mem_req_valid_o), 0);
    chk("rst_mid_idle", 32'(arb_idle_o), 1);
    tick();
    rst_n = 1'b1;
    mem_req_ready_i = 1'b1;
    set_resp(1, 5'h15, 32'h1234_5678);
    push_resp(1, 4'h5, 32'h1234_5678);
    @(negedge clk);
    tick();
    set_resp(0, 0, 0);
    @(negedge clk);
    chk("rst_stray_no_underflow", 32'(arb_idle_o), 1);
    tick();
    set_vec(1, 1, 32'hB000, 32'hBBBB_0000, 4'h0);
    @(negedge clk);
    chk("rst_after_grant", 32'(vec_req_ready_o), 1);
    push_req(1, 32'hB000, 32'hBBBB_0000, 5'h10);
    tick();
    set_vec(0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    @(negedge clk);

    chk("req_queue_drained", exp_req.size(), 0);
    chk("resp_queue_drained", exp_resp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
